led_pattern_gen: RTL and testbench
==================================

Name: led_pattern_gen

Overview:
- Multi-channel LED pattern driver; the parametrised successor to the single-output fixed-rate blinker on the top-level board LEDs.
- Drives CHANNELS LED outputs from one shared tick prescaler.
- Each channel has a runtime-selectable mode (OFF / ON / BLINK / BREATHE) and rate, set through a simple write port.
- Instantiated in the top level in place of the hard-wired LED assignments.

Parameters:
- CHANNELS, 8: number of LED outputs.
- PRESCALE, 50000: clk cycles per tick (1 kHz at 50 MHz); must be >= 2.
- RATE_W, 10: width of per-channel rate field.
- PWM_W, 8: BREATHE brightness/PWM resolution.
- DEFAULT_RATE, 499: reset rate of channel 0 (1 Hz blink at 1 kHz tick).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- cfg_we  in  1  config write strobe, single-cycle.
- cfg_ch  in  $clog2(CHANNELS)  target channel.
- cfg_mode  in  2  mode: 0 OFF, 1 ON, 2 BLINK, 3 BREATHE.
- cfg_rate  in  RATE_W  ticks per step minus one.
- sync  in  1  restart all channel phases together.
- led  out  CHANNELS  LED drive, registered.
- tick  out  1  one-cycle pulse per prescaler wrap (debug/chaining).

Behaviour:
- Reset (rst_n low, asynchronous):
  - led=0, tick=0, prescaler=0, PWM counter=0.
  - All phases, levels and brightness = 0; all directions = up.
  - Channel 0 mode=BLINK, rate=DEFAULT_RATE; all other channels mode=OFF, rate=0.
- Prescaler: counts 0..PRESCALE-1 and wraps. tick=1 in the cycle where count==PRESCALE-1, else 0.
- PWM counter: PWM_W bits, free-running, increments every clk, wraps naturally.
- Per-channel step divider: on each tick, if phase==rate then phase<=0 and a step event fires; else phase<=phase+1. With rate=0, a step fires every tick.
- OFF: led bit 0. Divider frozen.
- ON: led bit 1. Divider frozen.
- BLINK: each step toggles level; led bit = level. Period = 2*(rate+1) ticks.
- BREATHE:
  - Each step, brightness moves by 1 in the current direction.
  - On reaching 2^PWM_W-1, direction flips to down; on reaching 0, direction flips to up. Endpoint values are held for exactly one step.
  - led bit = (pwm_cnt < brightness). brightness 0 gives constant off; maximum gives on (2^PWM_W-1)/2^PWM_W of the time.
- Latency: led is registered, so it changes 1 clk after the internal level/brightness/pwm_cnt state changes.
- Config write (cfg_we=1):
  - Channel cfg_ch takes mode and rate at the next clk edge.
  - That channel's phase, level and brightness clear to 0; direction = up.
  - Other channels are unaffected. cfg_ch >= CHANNELS: write ignored.
- sync=1: clears prescaler, all phases, levels, brightness and directions. Modes and rates are kept.
- Simultaneous events:
  - sync with cfg_we: both apply. Config is written and all state is cleared.
  - cfg_we on a tick cycle: the written channel's clear wins over its step; other channels step normally.
  - sync on a tick cycle: sync wins and no step fires. tick output still pulses that cycle.
- Writing a channel's current mode/rate still restarts its phase; this is intended.

Decomposition:
- Package led_pkg: mode constants/enum (MODE_OFF, MODE_ON, MODE_BLINK, MODE_BREATHE) and the mode field width.
- Sub-module led_channel: one per channel via generate. Contains mode/rate registers, divider, level, brightness/direction and output compare.
- Top of block holds the prescaler, PWM counter, write decode and sync fan-out.

Test Plan (PRESCALE=4, CHANNELS=4, RATE_W=4, PWM_W=3, DEFAULT_RATE=1):
- Release reset, idle 40 clk -> tick pulses every 4 clk. led[0] toggles every 8 clk starting with first toggle 1 clk after 2nd tick; led[3:1]=0 throughout.
- Write ch2 mode=ON, then ch3 mode=OFF -> led[2]=1 from 2 clk after write strobe. led[3] stays 0, led[0] blink undisturbed.
- Write ch1 BREATHE rate=0 -> brightness sequence 1,2..7,6..0,1 one step per tick. Duty per 8-clk PWM window equals brightness/8; both endpoints are held one tick.
- Two channels BLINK rate=2 written at different times, then pulse sync -> afterwards both toggle on identical clk edges, first toggle 12 clk after sync.
- Assert cfg_we to ch1 on the same cycle as tick and sync -> ch1 takes new config, no step fires anywhere, all phases 0.
- Drop rst_n mid-pattern (asynchronously, off clock edge) -> led=0 immediately without clk. After release, ch0 blinks with DEFAULT_RATE and ch1..3 read OFF. Write to cfg_ch=4 (out of range, with a 3-bit cfg_ch override) -> no change.

Source files
------------

// File: rtl/led_pkg.sv
// Shared definitions for the multi-channel LED pattern generator.
package led_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_OFF     = 2'd0,
        MODE_ON      = 2'd1,
        MODE_BLINK   = 2'd2,
        MODE_BREATHE = 2'd3
    } led_mode_e;

endpackage

// File: rtl/led_pattern_gen_channel.sv
// One LED channel: mode/rate registers, tick-driven step divider,
// blink level, breathing triangle and registered output compare.
module led_channel
    import led_pkg::*;
#(
    parameter int                 RATE_W     = 10,
    parameter int                 PWM_W      = 8,
    parameter led_mode_e          RESET_MODE = MODE_OFF,
    parameter logic [RATE_W-1:0]  RESET_RATE = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_wr,
    input  logic [MODE_W-1:0]  i_mode,
    input  logic [RATE_W-1:0]  i_rate,
    input  logic               i_sync,
    input  logic               i_tick,
    input  logic [PWM_W-1:0]   i_pwm_cnt,
    output logic               o_led
);

    localparam logic [PWM_W-1:0] BRIGHT_PEN = PWM_W'((2 ** PWM_W) - 2);
    localparam logic [PWM_W-1:0] BRIGHT_ONE = PWM_W'(1);

    led_mode_e          r_mode;
    logic [RATE_W-1:0]  r_rate;
    logic [RATE_W-1:0]  r_phase;
    logic               r_level;
    logic [PWM_W-1:0]   r_bright;
    logic               r_dir_down;
    logic               r_led;
    logic               w_active;
    logic               w_led_next;

    assign w_active = (r_mode == MODE_BLINK) || (r_mode == MODE_BREATHE);

    always_comb begin
        w_led_next = 1'b0;
        case (r_mode)
            MODE_OFF:     w_led_next = 1'b0;
            MODE_ON:      w_led_next = 1'b1;
            MODE_BLINK:   w_led_next = r_level;
            MODE_BREATHE: w_led_next = (i_pwm_cnt < r_bright);
            default:      w_led_next = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode     <= RESET_MODE;
            r_rate     <= RESET_RATE;
            r_phase    <= '0;
            r_level    <= 1'b0;
            r_bright   <= '0;
            r_dir_down <= 1'b0;
            r_led      <= 1'b0;
        end else begin
            r_led <= w_led_next;
            if (i_wr || i_sync) begin
                if (i_wr) begin
                    r_mode <= led_mode_e'(i_mode);
                    r_rate <= i_rate;
                end
                r_phase    <= '0;
                r_level    <= 1'b0;
                r_bright   <= '0;
                r_dir_down <= 1'b0;
            end else if (i_tick && w_active) begin
                if (r_phase == r_rate) begin
                    r_phase <= '0;
                    if (r_mode == MODE_BLINK) begin
                        r_level <= ~r_level;
                    end else if (!r_dir_down) begin
                        // Flip on arrival so each endpoint lasts exactly one step.
                        r_bright <= r_bright + 1'b1;
                        if (r_bright == BRIGHT_PEN) r_dir_down <= 1'b1;
                    end else begin
                        r_bright <= r_bright - 1'b1;
                        if (r_bright == BRIGHT_ONE) r_dir_down <= 1'b0;
                    end
                end else begin
                    r_phase <= r_phase + 1'b1;
                end
            end
        end
    end

    assign o_led = r_led;

endmodule

// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern driver: shared tick prescaler, free-running PWM
// counter, config write decode and sync fan-out to the per-channel engines.
module led_pattern_gen
    import led_pkg::*;
#(
    parameter int CHANNELS     = 8,
    parameter int PRESCALE     = 50000,
    parameter int RATE_W       = 10,
    parameter int PWM_W        = 8,
    parameter int DEFAULT_RATE = 499,
    parameter int CFG_CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cfg_we,
    input  logic [CFG_CH_W-1:0]  cfg_ch,
    input  logic [MODE_W-1:0]    cfg_mode,
    input  logic [RATE_W-1:0]    cfg_rate,
    input  logic                 sync,
    output logic [CHANNELS-1:0]  led,
    output logic                 tick
);

    localparam int PS_W = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;

    logic [PS_W-1:0]  r_presc;
    logic [PWM_W-1:0] r_pwm_cnt;
    logic             w_tick;

    assign w_tick = (r_presc == PS_W'(PRESCALE - 1));
    assign tick   = w_tick;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc   <= '0;
            r_pwm_cnt <= '0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 1'b1;
            if (sync || w_tick) r_presc <= '0;
            else                r_presc <= r_presc + 1'b1;
        end
    end

    // Out-of-range channel numbers match no instance, so such writes vanish.
    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic w_wr;
        assign w_wr = cfg_we && (cfg_ch == CFG_CH_W'(g));

        led_channel #(
            .RATE_W     (RATE_W),
            .PWM_W      (PWM_W),
            .RESET_MODE ((g == 0) ? MODE_BLINK : MODE_OFF),
            .RESET_RATE ((g == 0) ? RATE_W'(DEFAULT_RATE) : RATE_W'(0))
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .i_wr      (w_wr),
            .i_mode    (cfg_mode),
            .i_rate    (cfg_rate),
            .i_sync    (sync),
            .i_tick    (w_tick),
            .i_pwm_cnt (r_pwm_cnt),
            .o_led     (led[g])
        );
    end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Self-checking bench for led_pattern_gen using a tick-count reference model.
module tb_led_pattern_gen;

    localparam int CH   = 4;
    localparam int PS   = 4;
    localparam int RW   = 4;
    localparam int PW   = 3;
    localparam int DR   = 1;
    localparam int CW   = 3;
    localparam int BMAX = (1 << PW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cfg_we;
    logic [CW-1:0] cfg_ch;
    logic [1:0]    cfg_mode;
    logic [RW-1:0] cfg_rate;
    logic          sync;
    logic [CH-1:0] led;
    logic          tick;

    always #5 clk = ~clk;

    led_pattern_gen #(
        .CHANNELS(CH), .PRESCALE(PS), .RATE_W(RW), .PWM_W(PW),
        .DEFAULT_RATE(DR), .CFG_CH_W(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_mode(cfg_mode), .cfg_rate(cfg_rate), .sync(sync),
        .led(led), .tick(tick)
    );

    // Model: per channel, ticks counted since its last restart.
    int            m_cnt, m_pwm;
    int            m_mode  [CH];
    int            m_rate  [CH];
    int            m_ticks [CH];
    logic [CH-1:0] m_led;
    int            n_tests = 0;
    int            n_fail  = 0;
    int            n_ticks;

    function automatic logic model_out(int ch);
        int steps, t, b;
        steps = m_ticks[ch] / (m_rate[ch] + 1);
        case (m_mode[ch])
            1: return 1'b1;
            2: return logic'(steps % 2);
            3: begin
                t = steps % (2 * BMAX);
                b = (t <= BMAX) ? t : (2 * BMAX - t);
                return (m_pwm < b);
            end
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        m_cnt = 0;
        m_pwm = 0;
        m_led = '0;
        for (int c = 0; c < CH; c++) begin
            m_mode[c]  = (c == 0) ? 2 : 0;
            m_rate[c]  = (c == 0) ? DR : 0;
            m_ticks[c] = 0;
        end
    endtask

    task automatic model_edge();
        logic [CH-1:0] nl;
        bit tk;
        tk = (m_cnt == PS - 1);
        for (int c = 0; c < CH; c++) nl[c] = model_out(c);
        for (int c = 0; c < CH; c++) begin
            if (cfg_we && int'(cfg_ch) == c) begin
                m_mode[c]  = int'(cfg_mode);
                m_rate[c]  = int'(cfg_rate);
                m_ticks[c] = 0;
            end else if (sync) begin
                m_ticks[c] = 0;
            end else if (tk && m_mode[c] >= 2) begin
                m_ticks[c]++;
            end
        end
        m_cnt = sync ? 0 : (m_cnt + 1) % PS;
        m_pwm = (m_pwm + 1) % (1 << PW);
        m_led = nl;
    endtask

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("led", 32'(led), 32'(m_led));
        check("tick", 32'(tick), 32'(m_cnt == PS - 1));
        if (tick) n_ticks++;
    endtask

    task automatic run(int n);
        for (int k = 0; k < n; k++) cyc();
    endtask

    task automatic wr(int ch, int mode, int rate);
        cfg_we   = 1'b1;
        cfg_ch   = CW'(ch);
        cfg_mode = 2'(mode);
        cfg_rate = RW'(rate);
        cyc();
        cfg_we   = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_mode = '0;
        cfg_rate = '0; sync = 1'b0;
        model_reset();
        #22;
        check("reset_led", 32'(led), 32'h0);
        check("reset_tick", 32'(tick), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        n_ticks = 0;
        run(40);
        check("idle_tick_count", 32'(n_ticks), 32'd10);

        wr(2, 1, 0);
        cyc();
        check("ch2_on", 32'(led[2]), 32'h1);
        wr(3, 0, 0);
        run(12);

        wr(1, 3, 0);
        run(4 * 2 * BMAX + 16);

        wr(2, 2, 2);
        run(5);
        wr(3, 2, 2);
        run(7);
        sync = 1'b1;
        cyc();
        sync = 1'b0;
        for (int k = 0; k < 30; k++) begin
            cyc();
            check("sync_lockstep", 32'(led[3]), 32'(led[2]));
        end

        for (int k = 0; k < 2 * PS && !tick; k++) cyc();
        check("tick_align", 32'(tick), 32'h1);
        cfg_we = 1'b1; cfg_ch = 3'd1; cfg_mode = 2'd2; cfg_rate = 4'd3;
        sync = 1'b1;
        cyc();
        cfg_we = 1'b0; sync = 1'b0;
        run(40);

        for (int k = 0; k < 300; k++) begin
            cfg_we   = ($urandom_range(3) == 0);
            cfg_ch   = CW'($urandom_range(7));
            cfg_mode = 2'($urandom_range(3));
            cfg_rate = RW'($urandom_range(3) == 0 ? $urandom_range(15) : $urandom_range(2));
            sync     = ($urandom_range(15) == 0);
            cyc();
        end
        cfg_we = 1'b0; sync = 1'b0;
        wr(0, 2, 0);
        run(6);

        #2 rst_n = 1'b0;
        #1;
        check("async_reset_led", 32'(led), 32'h0);
        check("async_reset_tick", 32'(tick), 32'h0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        check("reset_hold_led", 32'(led), 32'h0);
        rst_n = 1'b1;
        run(20);

        wr(4, 1, 0);
        wr(7, 3, 0);
        run(40);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout after %0d tests", n_tests);
        $fatal(1, "watchdog");
    end

endmodule
